rom_reverse_search: RTL and testbench
=====================================

# rom_reverse_search

Sequential reverse-lookup engine for the fixed 8-entry constant table (entries 0..7 = 1, 17, 23, 57, 234, 9, 4878, 9999; any further index = 9998). It takes a data value and returns the table index holding it, which is the inverse of the table's index-to-value read. It sits beside the table in datapaths that must turn a received value back into its code. The search is a start/done handshake that scans one entry per clock.

## Interface
- N, 3, index width; table depth 2^N.
- O, 14, entry/key width; constants truncated to O bits.

- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  request; accepted only when busy=0.
- key  input  O  value to find; sampled on the accepting edge.
- busy  output  1  high in SEARCH and DONE.
- done  output  1  one-cycle pulse; the result is valid.
- found  output  1  1 = key present in table.
- index  output  N  lowest matching index; 0 when found=0.

## Operation
- Reset: rst_n low at a rising edge forces IDLE. busy=0, done=0, found=0, index=0, internal key/pointer=0. This applies mid-search too; the search is abandoned and no done is issued.
- States:
  - IDLE: on start=1, latch key, set pointer=0, clear found/index, go to SEARCH.
  - SEARCH: each cycle compare table[pointer] with the latched key.
    - On a match (early exit enabled): found=1, index=pointer, go to DONE.
    - At pointer=2^N-1 with no match: found=0, index=0, go to DONE.
    - Otherwise pointer+1.
  - DONE: done=1 for this single cycle, then IDLE.
- start while busy=1 (including the DONE cycle) is ignored and not queued. key changes after acceptance have no effect.
- Duplicate values: the lowest index wins.
- The comparison is on all O bits after truncation.
- found/index hold their value after done until the next accepted start clears them.
- Pointer is N bits and never wraps; the search ends at 2^N-1.
- Outputs are registered. There is no combinational path from start/key to any output.

## Timing
- start sampled high at edge E0. The compare of entry i occurs at edge E0+1+i.
- Hit at index i (early exit): done high during the cycle after edge E0+i+1. Latency is i+1 cycles.
- Miss: done after edge E0+2^N, i.e. 8 cycles for N=3.
- busy rises after E0 and falls after the DONE cycle.
- Back-to-back: the earliest next accept is the edge ending the DONE cycle +1. Throughput is one search per latency+2 cycles.

## Configuration
- ROM_SEARCH_EARLY_EXIT_EN defined:
  - SEARCH leaves on the first match, so latency depends on the data (i+1 cycles).
- Not defined:
  - SEARCH always scans all 2^N entries, giving a constant 2^N-cycle latency (timing-invariant).
  - found/index record the lowest matching index; later matches do not overwrite it.
  - Outputs are otherwise identical.

## Test plan
- Reset: hold rst_n=0 for 2 cycles -> busy=0, done=0, found=0, index=0.
- Hit at entry 0: key=1, start pulse -> done 1 cycle after accept, found=1, index=0. Without the macro, done comes after 8 cycles with the same result.
- Hit at last entry: key=9999 -> done 8 cycles after accept, found=1, index=7.
- Miss: key=100 -> done 8 cycles after accept, found=0, index=0.
- start while busy:
  - Accept key=4878.
  - At cycle 2 pulse start with key=23 -> single done after 7 cycles, found=1, index=6. No second search.
- Reset mid-search:
  - Accept key=9999.
  - Drive rst_n=0 at cycle 3 -> next cycle all outputs 0, no done ever pulses.
  - A fresh start with key=57 after rst_n=1 -> found=1, index=3 after 4 cycles.

Source files
------------

// File: rtl/rom_reverse_search_if.sv
// Start/done handshake bundle for rom_reverse_search: the requester drives
// start/key and the engine returns busy/done/found/index.
interface rom_reverse_search_if #(
    parameter int N = 3,
    parameter int O = 14
);
    logic         start;
    logic [O-1:0] key;
    logic         busy;
    logic         done;
    logic         found;
    logic [N-1:0] index;

    modport master (
        output start,
        output key,
        input  busy,
        input  done,
        input  found,
        input  index
    );

    modport slave (
        input  start,
        input  key,
        output busy,
        output done,
        output found,
        output index
    );
endinterface

// File: rtl/rom_reverse_search.sv
// Reverse lookup over the fixed 8-entry constant table, one entry per clock.
// Define ROM_SEARCH_EARLY_EXIT_EN to stop on the first hit; otherwise every entry is scanned.
module rom_reverse_search #(
    parameter int N = 3,
    parameter int O = 14
) (
    input  logic                 clk,
    input  logic                 rst_n,
    rom_reverse_search_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Forward table read; indices beyond the populated entries return 9998.
    function automatic logic [O-1:0] table_entry(input logic [N-1:0] idx);
        logic [31:0] value;
        case ({{(32-N){1'b0}}, idx})
            32'd0:   value = 32'd1;
            32'd1:   value = 32'd17;
            32'd2:   value = 32'd23;
            32'd3:   value = 32'd57;
            32'd4:   value = 32'd234;
            32'd5:   value = 32'd9;
            32'd6:   value = 32'd4878;
            32'd7:   value = 32'd9999;
            default: value = 32'd9998;
        endcase
        return value[O-1:0];
    endfunction

    state_t       state_r, state_s;
    logic [O-1:0] key_r,   key_s;
    logic [N-1:0] ptr_r,   ptr_s;
    logic         found_r, found_s;
    logic [N-1:0] index_r, index_s;
    logic         done_r,  done_s;
    logic         busy_r,  busy_s;
    logic         hit_s;
    logic         last_s;

    assign hit_s  = (table_entry(ptr_r) == key_r);
    assign last_s = &ptr_r;

    // Next-state and next-output logic of the search FSM.
    always_comb begin
        state_s = state_r;
        key_s   = key_r;
        ptr_s   = ptr_r;
        found_s = found_r;
        index_s = index_r;
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    key_s   = bus.key;
                    ptr_s   = {N{1'b0}};
                    found_s = 1'b0;
                    index_s = {N{1'b0}};
                    state_s = SEARCH;
                end else begin
                    state_s = IDLE;
                end
            end
            SEARCH: begin
`ifdef ROM_SEARCH_EARLY_EXIT_EN
                if (hit_s) begin
                    found_s = 1'b1;
                    index_s = ptr_r;
                    state_s = DONE;
                end else if (last_s) begin
                    found_s = 1'b0;
                    index_s = {N{1'b0}};
                    state_s = DONE;
                end else begin
                    ptr_s = ptr_r + {{(N-1){1'b0}}, 1'b1};
                end
`else
                // Only the first hit is recorded so the lowest index wins.
                if (hit_s && !found_r) begin
                    found_s = 1'b1;
                    index_s = ptr_r;
                end else begin
                    found_s = found_r;
                end
                if (last_s) begin
                    state_s = DONE;
                end else begin
                    ptr_s = ptr_r + {{(N-1){1'b0}}, 1'b1};
                end
`endif
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
        done_s = (state_s == DONE);
        busy_s = (state_s != IDLE);
    end

    // State and registered outputs, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
            key_r   <= {O{1'b0}};
            ptr_r   <= {N{1'b0}};
            found_r <= 1'b0;
            index_r <= {N{1'b0}};
            done_r  <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            key_r   <= key_s;
            ptr_r   <= ptr_s;
            found_r <= found_s;
            index_r <= index_s;
            done_r  <= done_s;
            busy_r  <= busy_s;
        end
    end

    assign bus.busy  = busy_r;
    assign bus.done  = done_r;
    assign bus.found = found_r;
    assign bus.index = index_r;

endmodule

// File: tb/tb_rom_reverse_search.sv
// Scoreboard bench for rom_reverse_search: driver queues expected results from
// a table model, monitor checks them whenever done pulses.
module tb_rom_reverse_search;

    localparam int N = 3;
    localparam int O = 14;

    logic clk;
    logic rst_n;

    rom_reverse_search_if #(.N(N), .O(O)) bus ();

    rom_reverse_search #(.N(N), .O(O)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic         f;
        logic [N-1:0] idx;
        int           due;
    } exp_t;

    exp_t exp_q[$];
    int   vectors;
    int   miscompares;
    int   cyc;
    int   tbl[8] = '{1, 17, 23, 57, 234, 9, 4878, 9999};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: lowest index whose truncated value equals the key.
    task automatic model(input logic [O-1:0] k, output logic f,
                         output logic [N-1:0] idx, output int lat);
        f   = 1'b0;
        idx = '0;
        lat = 8;
        for (int i = 7; i >= 0; i--) begin
            if ((tbl[i] % 16384) == int'(k)) begin
                f   = 1'b1;
                idx = N'(i);
`ifdef ROM_SEARCH_EARLY_EXIT_EN
                lat = i + 1;
`else
                lat = 8;
`endif
            end
        end
    endtask

    task automatic check(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Drive a start pulse at a negedge; optionally record its expected result.
    task automatic issue(input logic [O-1:0] k, input bit push);
        exp_t         e;
        logic         f;
        logic [N-1:0] idx;
        int           lat;
        model(k, f, idx, lat);
        e.f   = f;
        e.idx = idx;
        e.due = cyc + 1 + lat;
        if (push) exp_q.push_back(e);
        bus.start = 1'b1;
        bus.key   = k;
        @(negedge clk);
        bus.start = 1'b0;
        bus.key   = O'($urandom_range(0, 16383));
        check("busy_after_accept", int'(bus.busy), 1);
    endtask

    task automatic wait_drain();
        int budget;
        budget = 0;
        while (exp_q.size() != 0 && budget < 40) begin
            @(negedge clk);
            budget++;
        end
        if (exp_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL timeout: %0d results pending, expected 0", exp_q.size());
            exp_q.delete();
        end
        repeat (12) @(negedge clk);
    endtask

    // Monitor: every done pulse must match the oldest expected result.
    always @(negedge clk) begin
        if (bus.done) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_done: done=1 at cycle %0d, expected no done", cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("found", int'(bus.found), int'(e.f));
                check("index", int'(bus.index), int'(e.idx));
                check("done_cycle", cyc, e.due);
            end
        end
    end

    initial begin
        logic [O-1:0] k;
        vectors     = 0;
        miscompares = 0;
        cyc         = 0;
        bus.start   = 1'b0;
        bus.key     = '0;
        rst_n       = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy",  int'(bus.busy),  0);
        check("rst_done",  int'(bus.done),  0);
        check("rst_found", int'(bus.found), 0);
        check("rst_index", int'(bus.index), 0);
        rst_n = 1'b1;
        @(negedge clk);

        issue(14'd1, 1'b1);    wait_drain();
        issue(14'd9999, 1'b1); wait_drain();
        issue(14'd100, 1'b1);  wait_drain();
        check("hold_found", int'(bus.found), 0);

        issue(14'd4878, 1'b1);
        @(negedge clk);
        bus.start = 1'b1;
        bus.key   = 14'd23;
        @(negedge clk);
        bus.start = 1'b0;
        wait_drain();
        check("hold_index", int'(bus.index), 6);

        issue(14'd9999, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_busy",  int'(bus.busy),  0);
        check("midrst_done",  int'(bus.done),  0);
        check("midrst_found", int'(bus.found), 0);
        check("midrst_index", int'(bus.index), 0);
        rst_n = 1'b1;
        @(negedge clk);
        issue(14'd57, 1'b1);   wait_drain();

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 1) == 0) k = O'(tbl[$urandom_range(0, 7)]);
            else k = O'($urandom_range(0, 16383));
            repeat ($urandom_range(0, 3)) @(negedge clk);
            issue(k, 1'b1);
            while (exp_q.size() != 0) @(negedge clk);
            @(negedge clk);
        end
        wait_drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
